// File: rtl/btn_debouncer.sv
// btn_debouncer -- per-channel push-button debouncer with press strobe.
//
// Each raw button level is brought into the clock domain by a two-flop
// synchronizer. A four-state FSM with a stability counter then accepts a
// level change only after DEBOUNCE_CYCLES consecutive agreeing samples.
//
// Ports (top):
//   i_clk    in   1      system clock, rising edge
//   i_reset  in   1      synchronous active-high reset
//   i_btn    in   N_BTN  raw asynchronous button levels, 1 = pressed
//   o_level  out  N_BTN  debounced level per channel
//   o_pulse  out  N_BTN  one-cycle strobe on the first debounced-pressed cycle
//
// Parameters: N_BTN (1..8), DEBOUNCE_CYCLES (>= 2).

module btn_debouncer_lane #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Encoding puts the "debounced pressed" states in the upper half so the
    // level output is simply state[1].
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] WAIT_PRESS   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    logic [1:0]    sync_q;
    logic          s;
    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    assign s = sync_q[1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = WAIT_PRESS;
                    cnt_nxt   = '0;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_nxt = WAIT_RELEASE;
                    cnt_nxt   = '0;
                end
            end
            WAIT_RELEASE: begin
                if (s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            state  <= IDLE;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            // Only the WAIT_PRESS -> PRESSED edge strobes; a bounce back
            // from WAIT_RELEASE into PRESSED must not re-fire.
            pulse  <= (state == WAIT_PRESS) && (state_nxt == PRESSED);
        end
    end

    assign level = state[1];
endmodule

module btn_debouncer #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_pulse
);
    for (genvar k = 0; k < N_BTN; k++) begin : g_lane
        btn_debouncer_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk  (i_clk),
            .rst  (i_reset),
            .btn  (i_btn[k]),
            .level(o_level[k]),
            .pulse(o_pulse[k])
        );
    end
endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with N_BTN=3, DEBOUNCE_CYCLES=4.
// "Cycle k" is the interval after rising edge k, where edge 0 is the first
// edge that samples the new stimulus. Inputs change 1 ns after an edge and
// outputs are sampled at the same point.
module tb_btn_debouncer;
    localparam int N  = 3;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] level;
    logic [N-1:0] pulse;

    int tests = 0;
    int fails = 0;

    btn_debouncer #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .i_btn  (btn),
        .o_level(level),
        .o_pulse(pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Release everything and let the channels settle back to IDLE.
    task automatic flush();
        btn = '0;
        rst = 1'b0;
        repeat (2 * DC + 6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++;
            if (level !== 3'b000) begin
                fails++;
                $display("FAIL reset_level cyc=%0d got=%b exp=000", k, level);
            end
            tests++;
            if (pulse !== 3'b000) begin
                fails++;
                $display("FAIL reset_pulse cyc=%0d got=%b exp=000", k, pulse);
            end
        end
        flush();
    endtask

    task automatic test_single_press();
        logic [N-1:0] ep, el;
        btn = 3'b001;
        for (int k = 0; k < 16; k++) begin
            tick();
            ep = (k == 6) ? 3'b001 : 3'b000;
            el = (k >= 6) ? 3'b001 : 3'b000;
            tests++;
            if (pulse !== ep) begin
                fails++;
                $display("FAIL press_pulse cyc=%0d got=%b exp=%b", k, pulse, ep);
            end
            tests++;
            if (level !== el) begin
                fails++;
                $display("FAIL press_level cyc=%0d got=%b exp=%b", k, level, el);
            end
        end
        // release: level falls at cycle 6 after the release edge, no pulse
        btn = 3'b000;
        for (int k = 0; k < 10; k++) begin
            tick();
            el = (k < 6) ? 3'b001 : 3'b000;
            tests++;
            if (level !== el) begin
                fails++;
                $display("FAIL release_level cyc=%0d got=%b exp=%b", k, level, el);
            end
            tests++;
            if (pulse !== 3'b000) begin
                fails++;
                $display("FAIL release_pulse cyc=%0d got=%b exp=000", k, pulse);
            end
        end
        flush();
    endtask

    task automatic test_glitch();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 6; k++) begin
                btn = (k < 3) ? 3'b010 : 3'b000;
                tick();
                tests++;
                if (pulse[1] !== 1'b0 || level[1] !== 1'b0) begin
                    fails++;
                    $display("FAIL glitch rep=%0d cyc=%0d got pulse=%b level=%b exp 0/0",
                             r, k, pulse[1], level[1]);
                end
            end
        end
        flush();
    endtask

    task automatic test_all_channels();
        logic [N-1:0] ep, el;
        btn = 3'b111;
        for (int k = 0; k < 32; k++) begin
            tick();
            btn = (k + 1 < 20) ? 3'b111 : 3'b000;
            ep = (k == 6) ? 3'b111 : 3'b000;
            el = (k >= 6 && k < 26) ? 3'b111 : 3'b000;
            tests++;
            if (pulse !== ep) begin
                fails++;
                $display("FAIL all_pulse cyc=%0d got=%b exp=%b", k, pulse, ep);
            end
            tests++;
            if (level !== el) begin
                fails++;
                $display("FAIL all_level cyc=%0d got=%b exp=%b", k, level, el);
            end
        end
        flush();
    endtask

    // Reset while counting in WAIT_PRESS (edges 4,5); re-debounce starts at edge 6.
    task automatic test_reset_mid();
        logic [N-1:0] ep, el;
        btn = 3'b100;
        for (int k = 0; k < 18; k++) begin
            tick();
            rst = (k + 1 == 4 || k + 1 == 5);
            ep = (k == 12) ? 3'b100 : 3'b000;
            el = (k >= 12) ? 3'b100 : 3'b000;
            tests++;
            if (pulse !== ep) begin
                fails++;
                $display("FAIL rstmid_pulse cyc=%0d got=%b exp=%b", k, pulse, ep);
            end
            tests++;
            if (level !== el) begin
                fails++;
                $display("FAIL rstmid_level cyc=%0d got=%b exp=%b", k, level, el);
            end
        end
        flush();
    endtask

    // Reset while PRESSED (edge 8); held button re-debounces from edge 9.
    task automatic test_reset_pressed();
        logic [N-1:0] ep, el;
        btn = 3'b001;
        for (int k = 0; k < 20; k++) begin
            tick();
            rst = (k + 1 == 8);
            ep = (k == 6 || k == 15) ? 3'b001 : 3'b000;
            el = ((k >= 6 && k < 8) || k >= 15) ? 3'b001 : 3'b000;
            tests++;
            if (pulse !== ep) begin
                fails++;
                $display("FAIL rstprs_pulse cyc=%0d got=%b exp=%b", k, pulse, ep);
            end
            tests++;
            if (level !== el) begin
                fails++;
                $display("FAIL rstprs_level cyc=%0d got=%b exp=%b", k, level, el);
            end
        end
        flush();
    endtask

    // Accepted press, then a 2-sample drop at edges 10,11 while held.
    task automatic test_bounce_held();
        logic [N-1:0] ep, el;
        btn = 3'b001;
        for (int k = 0; k < 26; k++) begin
            tick();
            btn = (k + 1 == 10 || k + 1 == 11) ? 3'b000 : 3'b001;
            ep = (k == 6) ? 3'b001 : 3'b000;
            el = (k >= 6) ? 3'b001 : 3'b000;
            tests++;
            if (pulse !== ep) begin
                fails++;
                $display("FAIL bounce_pulse cyc=%0d got=%b exp=%b", k, pulse, ep);
            end
            tests++;
            if (level !== el) begin
                fails++;
                $display("FAIL bounce_level cyc=%0d got=%b exp=%b", k, level, el);
            end
        end
        flush();
    endtask

    initial begin
        #1;
        test_reset();
        test_single_press();
        test_glitch();
        test_all_channels();
        test_reset_mid();
        test_reset_pressed();
        test_bounce_held();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/btn_debouncer.md
BTN_DEBOUNCER -- requirements
Module: btn_debouncer

Interface
REQ-001 Parameter N_BTN, default 3: number of independent button channels (A, B, OP loaders); legal range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable samples required to accept a level change; legal minimum 2.
REQ-003 i_clk  input  1  single system clock; all logic rising-edge triggered.
REQ-004 i_reset  input  1  synchronous, active-high reset, sampled on i_clk rising edge.
REQ-005 i_btn  input  N_BTN  raw asynchronous push-button levels, bit k = channel k, 1 = pressed.
REQ-006 o_level  output  N_BTN  debounced button level per channel.
REQ-007 o_pulse  output  N_BTN  single-cycle press strobe per channel, intended as the load enable of the downstream operand/opcode registers.

Function
REQ-008 Each i_btn bit SHALL pass through its own two-flop synchronizer before any other logic; s[k] denotes the second-flop output.
REQ-009 Each channel SHALL have its own FSM with states IDLE (released), WAIT_PRESS, PRESSED and WAIT_RELEASE, plus its own stability counter.
REQ-010 The counter width SHALL be clog2(DEBOUNCE_CYCLES), with no wrap: the counter only increments while below DEBOUNCE_CYCLES-1.
REQ-011 In IDLE with s=1, the FSM SHALL go to WAIT_PRESS with counter=0; in IDLE with s=0, it stays in IDLE.
REQ-012 In WAIT_PRESS with s=1, the counter SHALL increment, and the FSM SHALL go to PRESSED on the cycle the counter equals DEBOUNCE_CYCLES-1.
REQ-013 In WAIT_PRESS with s=0 (bounce), the FSM SHALL return to IDLE and clear the counter.
REQ-014 PRESSED/WAIT_RELEASE SHALL mirror IDLE/WAIT_PRESS with the polarity of s inverted; a bounce in WAIT_RELEASE returns to PRESSED.
REQ-015 o_level[k] SHALL be 1 exactly while channel k is in PRESSED or WAIT_RELEASE.
REQ-016 o_pulse[k] SHALL be registered and high for exactly one cycle, the first cycle in which o_level[k] is 1; it never asserts on release.
REQ-017 Latency: with i_btn[k] stable high from the first sampling edge, o_pulse[k] SHALL assert exactly DEBOUNCE_CYCLES+2 cycles after that edge.
REQ-018 Release latency: o_level[k] SHALL fall exactly DEBOUNCE_CYCLES+2 cycles after i_btn[k] is first sampled stable low.
REQ-019 A button held indefinitely SHALL produce exactly one o_pulse; a new pulse requires a debounced release followed by a debounced press.
REQ-020 Channels SHALL be fully independent; simultaneous presses on several channels SHALL yield pulses in the same cycle on each channel.
REQ-021 Glitches shorter than DEBOUNCE_CYCLES samples SHALL have no effect on o_level or o_pulse.

Reset
REQ-022 While i_reset=1, all synchronizer flops, counters, o_level and o_pulse SHALL be 0, and every FSM SHALL be in IDLE.
REQ-023 Reset asserted mid-operation (in any WAIT or PRESSED state) SHALL abort the operation, with no pulse emitted in or after the reset cycle.
REQ-024 After reset release with the button held, the channel SHALL re-debounce from IDLE and emit one pulse per REQ-017.

Verification (DEBOUNCE_CYCLES=4, N_BTN=3)
REQ-025 i_btn=3'b001 held from edge 0: o_pulse=3'b001 during cycle 6 only; o_level[0]=1 from cycle 6 onward.
REQ-026 i_btn[1] high for 3 cycles then low, repeated 5 times: o_pulse[1] and o_level[1] stay 0 throughout.
REQ-027 i_btn=3'b111 held 20 cycles: a single o_pulse=3'b111 in cycle 6; i_btn then released: o_level returns to 3'b000 six cycles after the release edge; no further pulse.
REQ-028 i_btn[2] held, i_reset=1 at cycle 4 for 2 cycles: no pulse before or during reset; after reset release, one pulse DEBOUNCE_CYCLES+2 cycles after the first post-reset edge.
REQ-029 Press is accepted, then i_btn[0] bounces low for 2 cycles while held: o_level[0] stays 1 and no second pulse occurs.
